// File: rtl/cursor_draw_if.sv
// Port bundle between cursor_draw, the paint control FSM and the framebuffer ports.
// The master side is the environment and the slave side is cursor_draw.
interface cursor_draw_if #(
    parameter int ADDR_W = 12
);
    logic              start;
    logic [7:0]        in_x;
    logic [7:0]        in_y;
    logic              paint_we;
    logic [ADDR_W-1:0] paint_addr;
    logic [7:0]        paint_data;
    logic              rd_en;
    logic [ADDR_W-1:0] rd_addr;
    logic [7:0]        rd_data;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        px_data;
    logic              busy;
    logic              done;

    modport master (
        output start, in_x, in_y, paint_we, paint_addr, paint_data, rd_data,
        input  rd_en, rd_addr, wr_en, wr_addr, px_data, busy, done
    );

    modport slave (
        input  start, in_x, in_y, paint_we, paint_addr, paint_data, rd_data,
        output rd_en, rd_addr, wr_en, wr_addr, px_data, busy, done
    );
endinterface

// File: rtl/cursor_draw.sv
// Draws the 5-pixel "+" cursor: restores the previously saved background first,
// then saves the new background and writes the cursor colour, one pixel per step.
module cursor_draw #(
    parameter int          SCREEN_W     = 64,
    parameter int          SCREEN_H     = 64,
    parameter int          ADDR_W       = 12,
    parameter logic [7:0]  CURSOR_COLOR = 8'hFF
) (
    input  logic         clk,
    input  logic         rst,
    cursor_draw_if.slave bus
);
    typedef enum logic [2:0] {IDLE, RESTORE, READ, SAVE, DONE} state_t;

    localparam logic signed [8:0] W_S = 9'(SCREEN_W);
    localparam logic signed [8:0] H_S = 9'(SCREEN_H);

    state_t            state, state_nx;
    logic [2:0]        k;
    logic [7:0]        x_lat, y_lat;
    logic              armed;
    logic [4:0]        saved_valid;
    logic [ADDR_W-1:0] saved_addr [5];
    logic [7:0]        saved_px   [5];

    logic signed [8:0] px, py;
    logic              clipped;
    logic [ADDR_W-1:0] pix_addr;

    // Coordinates of pixel k; 9-bit signed so an edge offset lands outside the screen instead of wrapping.
    always_comb begin
        px = $signed({1'b0, x_lat});
        py = $signed({1'b0, y_lat});
        case (k)
            3'd1:    px = px - 9'sd1;
            3'd2:    px = px + 9'sd1;
            3'd3:    py = py - 9'sd1;
            3'd4:    py = py + 9'sd1;
            default: ;
        endcase
        clipped  = px[8] || (px >= W_S) || py[8] || (py >= H_S);
        pix_addr = ADDR_W'(32'(unsigned'(py)) * 32'(SCREEN_W) + 32'(unsigned'(px)));
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (bus.start && armed) state_nx = RESTORE;
            RESTORE: if (k == 3'd4) state_nx = READ;
            READ:    state_nx = SAVE;
            SAVE:    state_nx = (k == 3'd4) ? DONE : READ;
            DONE:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // NOTE: every output gets a default before the case, so no path leaves one unassigned and no latch is inferred.
    always_comb begin
        bus.rd_en   = 1'b0;
        bus.rd_addr = '0;
        bus.wr_en   = 1'b0;
        bus.wr_addr = '0;
        bus.px_data = '0;
        bus.busy    = (state != IDLE);
        bus.done    = (state == DONE);
        case (state)
            RESTORE: if (saved_valid[k]) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = saved_addr[k];
                bus.px_data = saved_px[k];
            end
            READ: if (!clipped) begin
                bus.rd_en   = 1'b1;
                bus.rd_addr = pix_addr;
            end
            SAVE: if (!clipped) begin
                bus.wr_en   = 1'b1;
                bus.wr_addr = pix_addr;
                bus.px_data = CURSOR_COLOR;
            end
            default: ;
        endcase
    end

    // NOTE: saved_addr/saved_px are left out of reset; saved_valid alone decides whether an entry means anything.
    always_ff @(posedge clk) begin
        if (rst) begin
            armed       <= 1'b1;
            saved_valid <= '0;
            k           <= '0;
            x_lat       <= '0;
            y_lat       <= '0;
        end else begin
            // Keep saved backgrounds coherent with paint writes landing under the cursor.
            for (int j = 0; j < 5; j++) begin
                if (bus.paint_we && saved_valid[j] && (bus.paint_addr == saved_addr[j]))
                    saved_px[j] <= bus.paint_data;
            end
            case (state)
                IDLE: begin
                    if (bus.start && armed) begin
                        x_lat <= bus.in_x;
                        y_lat <= bus.in_y;
                        k     <= '0;
                        armed <= 1'b0;
                    end else if (!bus.start) begin
                        armed <= 1'b1;
                    end
                end
                RESTORE: begin
                    if (k == 3'd4) begin
                        k           <= '0;
                        saved_valid <= '0;
                    end else begin
                        k <= k + 3'd1;
                    end
                end
                SAVE: begin
                    if (!clipped) begin
                        saved_px[k]    <= (bus.paint_we && (bus.paint_addr == pix_addr)) ? bus.paint_data
                                                                                         : bus.rd_data;
                        saved_addr[k]  <= pix_addr;
                        saved_valid[k] <= 1'b1;
                    end
                    if (k != 3'd4) k <= k + 3'd1;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_cursor_draw.sv
// Self-checking bench for cursor_draw: framebuffer model, reference cursor model feeding
// read/write scoreboards, a table of draw positions and hand-built corner sequences.
module tb_cursor_draw;
    localparam int AW = 12;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic fb_clear = 1'b1;

    cursor_draw_if #(.ADDR_W(AW)) bus ();

    cursor_draw #(
        .SCREEN_W(64), .SCREEN_H(64), .ADDR_W(AW), .CURSOR_COLOR(8'hFF)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    typedef struct { logic [AW-1:0] a; logic [7:0] d; } ev_t;
    typedef struct { int x; int y; int n_rest; int n_draw; } vec_t;

    ev_t        exp_wr[$];
    ev_t        exp_rd[$];
    logic [7:0] fb     [4096];
    logic [7:0] ref_fb [4096];
    logic       sv_v    [5];
    logic [AW-1:0] sv_addr [5];
    logic [7:0] sv_px   [5];
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string name, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, req, req);
        end
    endtask

    task automatic push_ev(input logic is_wr, input logic [AW-1:0] a, input logic [7:0] d);
        ev_t e;
        e.a = a;
        e.d = d;
        if (is_wr) exp_wr.push_back(e);
        else       exp_rd.push_back(e);
    endtask

    // Framebuffer: 1-cycle read latency; a cursor write beats a paint write to the same address.
    always @(posedge clk) begin
        if (fb_clear) begin
            for (int i = 0; i < 4096; i++) fb[i] <= 8'h22;
        end else begin
            if (bus.rd_en)    bus.rd_data <= fb[bus.rd_addr];
            if (bus.paint_we) fb[bus.paint_addr] <= bus.paint_data;
            if (bus.wr_en)    fb[bus.wr_addr] <= bus.px_data;
        end
    end

    always @(negedge clk) begin
        ev_t e;
        if (bus.wr_en) begin
            check("wr_expected", int'(exp_wr.size() != 0), 1);
            if (exp_wr.size() != 0) begin
                e = exp_wr.pop_front();
                check("wr_addr", int'(bus.wr_addr), int'(e.a));
                check("wr_data", int'(bus.px_data), int'(e.d));
            end
        end
        if (bus.rd_en) begin
            check("rd_expected", int'(exp_rd.size() != 0), 1);
            if (exp_rd.size() != 0) begin
                e = exp_rd.pop_front();
                check("rd_addr", int'(bus.rd_addr), int'(e.a));
            end
        end
        if (bus.rd_en || bus.wr_en) check("rd_wr_exclusive", int'(bus.rd_en && bus.wr_en), 0);
    end

    // Reference: cycle c after the accepting cycle; restore j at c=1+j, read k at 6+2k, write k at 7+2k.
    task automatic model_draw(input int x, input int y, input int abort_cyc,
                              input int paint_cyc, input logic [7:0] paint_d);
        int dx[5] = '{0, -1, 1, 0, 0};
        int dy[5] = '{0, 0, 0, -1, 1};
        int last  = (abort_cyc > 0) ? abort_cyc : 16;
        for (int j = 0; j < 5; j++) begin
            if (sv_v[j] && (1 + j <= last)) begin
                push_ev(1'b1, sv_addr[j], sv_px[j]);
                ref_fb[sv_addr[j]] = sv_px[j];
            end
        end
        for (int j = 0; j < 5; j++) sv_v[j] = 1'b0;
        for (int k = 0; k < 5; k++) begin
            int px = x + dx[k];
            int py = y + dy[k];
            logic [AW-1:0] a;
            if (px < 0 || px >= 64 || py < 0 || py >= 64) continue;
            a = AW'(py * 64 + px);
            if (6 + 2 * k <= last) push_ev(1'b0, a, 8'h00);
            if (7 + 2 * k <= last) begin
                sv_px[k]   = (paint_cyc == 7 + 2 * k) ? paint_d : ref_fb[a];
                sv_addr[k] = a;
                sv_v[k]    = 1'b1;
                push_ev(1'b1, a, 8'hFF);
                ref_fb[a]  = 8'hFF;
            end
        end
        if (abort_cyc > 0) for (int j = 0; j < 5; j++) sv_v[j] = 1'b0;
    endtask

    // Called at a falling edge with the DUT idle and armed; cycle 0 is the accepting cycle.
    task automatic do_draw(input int x, input int y, input int hold, input int abort_cyc,
                           input int paint_cyc, input logic [7:0] paint_d,
                           output int n_rest, output int n_draw, output int done_cyc,
                           output int n_done, output int n_late_busy);
        int last = (abort_cyc > 0) ? abort_cyc : 16 + hold;
        model_draw(x, y, abort_cyc, paint_cyc, paint_d);
        n_rest = 0; n_draw = 0; done_cyc = -1; n_done = 0; n_late_busy = 0;
        bus.in_x  = 8'(x);
        bus.in_y  = 8'(y);
        bus.start = 1'b1;
        for (int cyc = 1; cyc <= last; cyc++) begin
            @(negedge clk);
            bus.paint_we = 1'b0;
            if (bus.wr_en) begin
                if (cyc <= 5) n_rest++;
                else          n_draw++;
            end
            if (bus.done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = cyc;
            end
            if (cyc > 16 && bus.busy) n_late_busy++;
            if (cyc == paint_cyc) begin
                bus.paint_we   = 1'b1;
                bus.paint_addr = AW'(y * 64 + x);
                bus.paint_data = paint_d;
            end
            if (cyc == abort_cyc) rst = 1'b1;
        end
        bus.start = 1'b0;
        if (abort_cyc == 0) repeat (2) @(negedge clk);
    endtask

    task automatic paint(input logic [AW-1:0] a, input logic [7:0] d);
        bus.paint_we   = 1'b1;
        bus.paint_addr = a;
        bus.paint_data = d;
        ref_fb[a] = d;
        for (int j = 0; j < 5; j++) if (sv_v[j] && sv_addr[j] == a) sv_px[j] = d;
        @(negedge clk);
        bus.paint_we = 1'b0;
        @(negedge clk);
    endtask

    initial begin
        vec_t vecs[7];
        int nr, nd, dc, ndn, nlb;
        vecs = '{'{10, 10, 0, 5}, '{11, 10, 5, 5}, '{0, 0, 5, 3}, '{63, 63, 3, 3},
                 '{64, 5, 3, 1}, '{200, 200, 1, 0}, '{5, 5, 0, 5}};
        bus.start = 1'b0; bus.in_x = '0; bus.in_y = '0;
        bus.paint_we = 1'b0; bus.paint_addr = '0; bus.paint_data = '0;
        for (int i = 0; i < 4096; i++) ref_fb[i] = 8'h22;
        for (int j = 0; j < 5; j++) sv_v[j] = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_busy",  int'(bus.busy), 0);
        check("rst_done",  int'(bus.done), 0);
        check("rst_rd_en", int'(bus.rd_en), 0);
        check("rst_wr_en", int'(bus.wr_en), 0);
        check("rst_addr_data", int'({bus.rd_addr, bus.wr_addr, bus.px_data}), 0);
        rst = 1'b0;
        fb_clear = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 7; i++) begin
            do_draw(vecs[i].x, vecs[i].y, 0, 0, 0, 8'h00, nr, nd, dc, ndn, nlb);
            check($sformatf("v%0d_restore_writes", i), nr, vecs[i].n_rest);
            check($sformatf("v%0d_cursor_writes", i), nd, vecs[i].n_draw);
            check($sformatf("v%0d_done_cycle", i), dc, 16);
            check($sformatf("v%0d_done_pulses", i), ndn, 1);
        end

        // Paint over the saved centre of (5,5); the next restore must write the painted colour.
        paint(AW'(325), 8'h3C);
        do_draw(20, 20, 0, 0, 0, 8'h00, nr, nd, dc, ndn, nlb);
        check("paint_restore_writes", nr, 5);
        check("paint_fb325", int'(fb[325]), 8'h3C);

        // Start held for 40 more cycles: one pulse, no retrigger until start drops.
        do_draw(30, 30, 40, 0, 0, 8'h00, nr, nd, dc, ndn, nlb);
        check("hold_done_pulses", ndn, 1);
        check("hold_late_busy", nlb, 0);
        do_draw(31, 30, 0, 0, 0, 8'h00, nr, nd, dc, ndn, nlb);
        check("rearm_done_cycle", dc, 16);
        check("rearm_restore_writes", nr, 5);

        // Paint hits the centre in its own SAVE cycle: paint data is what gets saved.
        do_draw(40, 40, 0, 0, 7, 8'h5A, nr, nd, dc, ndn, nlb);
        do_draw(45, 45, 0, 0, 0, 8'h00, nr, nd, dc, ndn, nlb);
        check("save_paint_fb2600", int'(fb[2600]), 8'h5A);

        // Reset during cycle 7 of a draw.
        do_draw(12, 12, 0, 7, 0, 8'h00, nr, nd, dc, ndn, nlb);
        @(negedge clk);
        check("abort_busy", int'(bus.busy), 0);
        check("abort_strobes", int'({bus.rd_en, bus.wr_en, bus.done}), 0);
        check("abort_addr_data", int'({bus.rd_addr, bus.wr_addr, bus.px_data}), 0);
        rst = 1'b0;
        @(negedge clk);
        do_draw(12, 12, 0, 0, 0, 8'h00, nr, nd, dc, ndn, nlb);
        check("post_abort_restore_writes", nr, 0);
        check("post_abort_cursor_writes", nd, 5);
        check("post_abort_done_cycle", dc, 16);

        check("wr_queue_drained", exp_wr.size(), 0);
        check("rd_queue_drained", exp_rd.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
